// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter for 32 requesters driving a registered 5-bit winner index and its one-hot decode.
// Define GRANT_TIMEOUT_EN to force a release after MAX_HOLD cycles of ownership.
module decoder_rr_arbiter #(
  parameter int N_REQ    = 32,
  parameter int IDX_W    = 5,
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx,
  output logic [N_REQ-1:0] grant_onehot,
  output logic             busy,
  output logic             timeout
);

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  if (N_REQ != 2 ** IDX_W) begin : g_bad_width
    $error("N_REQ must equal 2**IDX_W");
  end
  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_hold
    $error("MAX_HOLD must be in 2..255");
  end

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
  logic               grant_valid_q, grant_valid_d;
  logic [N_REQ-1:0]   grant_onehot_q, grant_onehot_d;
  logic               busy_q, busy_d;
  logic               release_norm;
  logic               hold_expired;
  logic               found;
  logic [IDX_W-1:0]   winner;
  logic [IDX_W-1:0]   cand;

  // Rotating priority scan: first set request at or after ptr, wrapping modulo N_REQ.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = ptr_q + IDX_W'(i);
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign release_norm = done | ~req[grant_idx_q];

`ifdef GRANT_TIMEOUT_EN
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic       timeout_q, timeout_d;

  assign hold_expired = (hold_cnt_q == 8'(MAX_HOLD - 1));

  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (state_q == IDLE)       hold_cnt_d = '0;
    else if (state_q == GRANT) hold_cnt_d = hold_cnt_q + 8'd1;
    // A coincident done/req-drop makes this an ordinary release, so no pulse.
    timeout_d = (state_q == GRANT) && hold_expired && !release_norm;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign hold_expired = 1'b0;
  assign timeout      = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    grant_idx_d   = grant_idx_q;
    grant_valid_d = grant_valid_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          grant_idx_d   = winner;
          grant_valid_d = 1'b1;
          state_d       = GRANT;
        end
      end
      GRANT: begin
        if (release_norm || hold_expired) begin
          grant_valid_d = 1'b0;
          ptr_d         = grant_idx_q + IDX_W'(1);
          state_d       = RELEASE;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d         = (state_d != IDLE);
    grant_onehot_d = grant_valid_d ? (N_REQ'(1) << grant_idx_d) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      ptr_q          <= '0;
      grant_idx_q    <= '0;
      grant_valid_q  <= 1'b0;
      grant_onehot_q <= '0;
      busy_q         <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      grant_idx_q    <= grant_idx_d;
      grant_valid_q  <= grant_valid_d;
      grant_onehot_q <= grant_onehot_d;
      busy_q         <= busy_d;
    end
  end

  assign grant_valid  = grant_valid_q;
  assign grant_idx    = grant_idx_q;
  assign grant_onehot = grant_onehot_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Self-checking bench for decoder_rr_arbiter: directed scenarios plus random traffic against a
// behavioural model of ownership, release gap and rotating priority.
module tb_decoder_rr_arbiter;

  localparam int MAX_HOLD = 16;

  logic        clk;
  logic        rst;
  logic [31:0] req;
  logic        done;
  logic        grant_valid;
  logic [4:0]  grant_idx;
  logic [31:0] grant_onehot;
  logic        busy;
  logic        timeout;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state
  bit m_valid;
  int m_idx;
  int m_ptr;
  bit m_in_release;
  int m_hold;
  bit m_timeout;

  decoder_rr_arbiter #(.N_REQ(32), .IDX_W(5), .MAX_HOLD(MAX_HOLD)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .done         (done),
    .grant_valid  (grant_valid),
    .grant_idx    (grant_idx),
    .grant_onehot (grant_onehot),
    .busy         (busy),
    .timeout      (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_idx = 0; m_ptr = 0; m_in_release = 0; m_hold = 0; m_timeout = 0;
  endtask

  task automatic model_step(input logic [31:0] r, input logic d);
    bit norm;
    bit to;
    m_timeout = 0;
    if (m_valid) begin
      norm = d || !r[m_idx];
`ifdef GRANT_TIMEOUT_EN
      to = (m_hold == MAX_HOLD - 1);
`else
      to = 0;
`endif
      if (norm || to) begin
        m_valid      = 0;
        m_ptr        = (m_idx + 1) % 32;
        m_in_release = 1;
        m_timeout    = to && !norm;
      end else begin
        m_hold++;
      end
    end else if (m_in_release) begin
      m_in_release = 0;
    end else if (r != 0) begin
      for (int k = 0; k < 32; k++) begin
        if (r[(m_ptr + k) % 32]) begin
          m_idx   = (m_ptr + k) % 32;
          m_valid = 1;
          m_hold  = 0;
          break;
        end
      end
    end
  endtask

  task automatic compare_all();
    check("grant_valid", 32'(grant_valid), 32'(m_valid));
    check("grant_idx", 32'(grant_idx), 32'(m_idx));
    check("grant_onehot", grant_onehot, m_valid ? (32'd1 << m_idx) : 32'd0);
    check("busy", 32'(busy), 32'(m_valid || m_in_release));
    check("timeout", 32'(timeout), 32'(m_timeout));
  endtask

  // Drive at the falling edge, let the DUT take one rising edge, compare 1 ns later.
  task automatic cycle(input logic [31:0] r, input logic d);
    req  = r;
    done = d;
    @(posedge clk);
    model_step(r, d);
    #1;
    compare_all();
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] r;
    int n_valid;
    int n_to;

    rst = 1'b1; req = '0; done = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    rst = 1'b0;
    repeat (10) cycle(32'h0, 1'b0);

    // All requesting: strict rotation 0..31 then back to 0.
    cycle(32'hFFFF_FFFF, 1'b0);
    for (int g = 0; g <= 32; g++) begin
      check("rotation_idx", 32'(grant_idx), 32'(g % 32));
      check("onehot_count", 32'($countones(grant_onehot)), 32'd1);
      if (g < 32) begin
        cycle(32'hFFFF_FFFF, 1'b1);
        cycle(32'hFFFF_FFFF, 1'b0);
        cycle(32'hFFFF_FFFF, 1'b0);
      end
    end
    cycle(32'h0, 1'b1);
    cycle(32'h0, 1'b0);

    // Single requester 5: grant, done after 4 cycles, regrant after the gap.
    cycle(32'h0000_0020, 1'b0);
    check("req5_idx", 32'(grant_idx), 32'd5);
    check("req5_onehot", grant_onehot, 32'h0000_0020);
    repeat (3) cycle(32'h0000_0020, 1'b0);
    cycle(32'h0000_0020, 1'b1);
    check("req5_dropped", 32'(grant_valid), 32'd0);
    cycle(32'h0000_0020, 1'b0);
    check("req5_gap", 32'(grant_valid), 32'd0);
    cycle(32'h0000_0020, 1'b0);
    check("req5_regrant", 32'(grant_valid), 32'd1);
    cycle(32'h0, 1'b0);
    cycle(32'h0, 1'b0);

    // Pointer wrap: after granting 29, requests 0 and 1 go 0 then 1.
    cycle(32'h2000_0000, 1'b0);
    check("wrap_29", 32'(grant_idx), 32'd29);
    cycle(32'h2000_0000, 1'b1);
    cycle(32'h0000_0003, 1'b0);
    cycle(32'h0000_0003, 1'b0);
    check("wrap_0", 32'(grant_idx), 32'd0);
    cycle(32'h0000_0003, 1'b1);
    cycle(32'h0000_0003, 1'b0);
    cycle(32'h0000_0003, 1'b0);
    check("wrap_1", 32'(grant_idx), 32'd1);
    cycle(32'h0, 1'b1);
    cycle(32'h0, 1'b0);

    // Owner 7 drops its request while 9 waits.
    cycle(32'h0000_0080, 1'b0);
    check("drop_own7", 32'(grant_idx), 32'd7);
    cycle(32'h0000_0280, 1'b0);
    check("drop_hold7", 32'(grant_idx), 32'd7);
    cycle(32'h0000_0200, 1'b0);
    check("drop_release", 32'(grant_valid), 32'd0);
    check("drop_busy", 32'(busy), 32'd1);
    cycle(32'h0000_0200, 1'b0);
    check("drop_idle", 32'(grant_valid), 32'd0);
    cycle(32'h0000_0200, 1'b0);
    check("drop_own9", 32'(grant_idx), 32'd9);
    cycle(32'h0, 1'b1);
    cycle(32'h0, 1'b0);
    cycle(32'h0, 1'b0);

`ifdef GRANT_TIMEOUT_EN
    n_valid = 0;
    n_to    = 0;
    for (int c = 0; c < MAX_HOLD + 2; c++) begin
      cycle(32'h0000_0008, 1'b0);
      if (grant_valid) n_valid++;
      if (timeout) n_to++;
    end
    check("timeout_hold_len", 32'(n_valid), 32'(MAX_HOLD));
    check("timeout_pulses", 32'(n_to), 32'd1);
    cycle(32'h0, 1'b0);
    cycle(32'h0, 1'b0);
`endif

    // Random traffic; requests usually persist so owners hold for a while.
    r = 32'h0;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 3))
          0: r = $urandom & $urandom & $urandom;
          1: r = 32'd1 << $urandom_range(0, 31);
          2: r = 32'hFFFF_FFFF;
          default: r = ($urandom_range(0, 1) == 0) ? 32'h0 : $urandom;
        endcase
      end
      cycle(r, ($urandom_range(0, 5) == 0));
    end

    // Asynchronous reset mid-grant drops the grant before the next edge.
    cycle(32'h0, 1'b1);
    cycle(32'h0, 1'b0);
    cycle(32'h0, 1'b0);
    cycle(32'h0000_1000, 1'b0);
    check("pre_rst_own", 32'(grant_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(grant_valid), 32'd0);
    check("async_rst_onehot", grant_onehot, 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_idx", 32'(grant_idx), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    cycle(32'h0000_1000, 1'b0);
    cycle(32'h0000_1000, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/decoder_rr_arbiter.md
Name: decoder_rr_arbiter

Overview:
- Round-robin arbiter sharing one 32-way decoded resource (one-hot select bus) among 32 requesters.
- Registers a 5-bit winner index and drives the fully decoded one-hot grant from it.
- Guarantees break-before-make between owners and fair rotation.
- Sits between the requesting agents and the 5-to-32 select decode feeding the shared resource.

Parameters:
- N_REQ, 32, number of requesters. Must equal 2**IDX_W.
- IDX_W, 5, width of the grant index.
- MAX_HOLD, 16, maximum cycles one owner may hold the grant. Used only with GRANT_TIMEOUT_EN. Legal range 2..255.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req  input  32  request vector; bit i = requester i wants the resource.
- done  input  1  current owner releases the resource; sampled only in GRANT.
- grant_valid  output  1  a grant is active.
- grant_idx  output  5  index of the current owner; holds its last value when grant_valid=0.
- grant_onehot  output  32  one-hot decode of grant_idx when grant_valid=1; all zeros otherwise.
- busy  output  1  state is not IDLE.
- timeout  output  1  one-cycle pulse on forced release (GRANT_TIMEOUT_EN only).

Behaviour:
- Reset (async, active-high):
  - state=IDLE, ptr=0, grant_valid=0, grant_idx=0, grant_onehot=0, busy=0, timeout=0, hold_cnt=0.
  - Assertion mid-grant drops the grant immediately, without waiting for a clock edge.
- All outputs are registered; grant_onehot is derived from the registered state with no combinational path from req.
- States: IDLE, GRANT, RELEASE.
- IDLE:
  - If req!=0 at a clock edge, the winner is the first set bit scanning ptr, ptr+1, ... 31, 0, ... ptr-1 (wrap mod 32).
  - Same edge: grant_idx<=winner, grant_valid<=1, state<=GRANT, hold_cnt<=0.
  - Latency: grant is visible 1 cycle after req is sampled.
  - If req==0, remain in IDLE.
- GRANT:
  - Hold while req[grant_idx]=1 and done=0. Changes on other req bits are ignored.
  - Release condition: done=1, or req[grant_idx]=0, or a timeout. Simultaneous causes produce one release.
  - On release at an edge: grant_valid<=0, ptr<=grant_idx+1 (31 wraps to 0), state<=RELEASE.
- RELEASE:
  - Exactly one cycle with grant_valid=0 (break-before-make), then state<=IDLE.
  - Requests are not evaluated in RELEASE. Minimum idle gap between grants is 2 cycles; a new owner is granted no earlier than 2 cycles after the release edge.
- Fairness: the just-released index has lowest priority next round. With all 32 requesting continuously, grants cycle 0,1,2,...,31,0,...
- done outside GRANT: ignored, no effect.
- req dropped before being granted: that requester is not granted; no memory of past requests.
- Single requester re-requesting: it is re-granted after the 2-cycle gap, regardless of ptr.

Optional Feature:
- Macro: GRANT_TIMEOUT_EN.
- Defined:
  - hold_cnt (8 bits) increments each cycle in GRANT.
  - When hold_cnt==MAX_HOLD-1 and no other release cause is present, the next edge forces a release. timeout=1 for exactly the cycle following that edge.
  - If done and the timeout coincide, the release counts as a normal release and timeout stays 0.
  - Owner holds for at most MAX_HOLD cycles.
- Undefined: hold_cnt is not implemented, the timeout port is tied 0, and an owner may hold indefinitely.

Test Plan:
- Reset release with req=0 -> grant_valid=0, grant_onehot=0, grant_idx=0, busy=0 for 10 cycles.
- req=32'h0000_0020 held; done pulsed 4 cycles after grant:
  - grant_idx=5 and grant_onehot=32'h0000_0020 one cycle after req.
  - grant drops the cycle after done.
  - regrant occurs after the 2-cycle gap.
- req=32'hFFFF_FFFF constant, done pulsed every grant -> grant_idx sequence 0,1,...,31,0 with no repeats and no skips; grant_onehot always has exactly one bit set when valid.
- ptr=30 (after granting 29), req=32'h0000_0003 -> wrap: grant_idx=0, then 1.
- Owner 7 drops req[7] while req[9]=1:
  - grant released next edge.
  - RELEASE cycle has grant_valid=0.
  - grant_idx=9 two cycles later.
- GRANT_TIMEOUT_EN, MAX_HOLD=16, req[3] held, done=0:
  - grant lasts exactly 16 cycles.
  - timeout pulses once.
  - rst asserted mid-grant -> grant_valid=0 immediately, before the next edge.
